// File: rtl/dmem_arbiter.sv
// Arbiter and access sequencer for the single-port data memory. It serves the pipeline MEM stage
// and the loader port; the CPU normally has priority, but a loader that keeps losing eventually wins.
module dmem_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  output logic [31:0]       cpu_rdata_o,
  output logic              cpu_stall_o,
  input  logic              ld_req_i,
  input  logic              ld_we_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [31:0]       ld_wdata_i,
  output logic              ld_ack_o,
  output logic [31:0]       ld_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  output logic              busy_o
);

  localparam logic [3:0] C_MAX_WAIT = 4'(MAX_WAIT);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE_CPU = 3'd1,
    S_RESP_CPU  = 3'd2,
    S_ISSUE_LD  = 3'd3,
    S_RESP_LD   = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [3:0]         r_wait_cnt;
  logic [3:0]         w_wait_next;
  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [31:0]        r_wdata;
  logic [31:0]        r_cpu_rdata;
  logic [31:0]        r_ld_rdata;

  logic               w_cpu_req;
  logic               w_ld_starved;
  logic               w_idle;
  logic               w_grant_cpu;
  logic               w_grant_ld;
  logic               w_cpu_load_resp;
  logic               w_ld_load_resp;
  logic [ADDR_W-1:0]  w_cpu_addr_al;
  logic [ADDR_W-1:0]  w_ld_addr_al;
  logic               w_unused;

  assign w_cpu_req    = cpu_req_i & start_i;
  assign w_idle       = (r_state == S_IDLE);
  assign w_ld_starved = ld_req_i & (r_wait_cnt == C_MAX_WAIT);
  assign w_grant_ld   = w_idle & (w_ld_starved | (~w_cpu_req & ld_req_i));
  assign w_grant_cpu  = w_idle & ~w_ld_starved & w_cpu_req;

  // Misaligned addresses silently round down to the containing word.
  assign w_cpu_addr_al = {cpu_addr_i[ADDR_W-1:2], 2'b00};
  assign w_ld_addr_al  = {ld_addr_i[ADDR_W-1:2], 2'b00};
  assign w_unused      = ^{cpu_addr_i[31:ADDR_W], cpu_addr_i[1:0], ld_addr_i[1:0]};

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_grant_ld)       w_next_state = S_ISSUE_LD;
        else if (w_grant_cpu) w_next_state = S_ISSUE_CPU;
      end
      S_ISSUE_CPU: w_next_state = S_RESP_CPU;
      S_RESP_CPU:  w_next_state = S_IDLE;
      S_ISSUE_LD:  w_next_state = S_RESP_LD;
      S_RESP_LD:   w_next_state = S_IDLE;
      default:     w_next_state = S_IDLE;
    endcase
  end

  // Loader losses are only counted at arbitration points while it is actually waiting.
  always_comb begin
    w_wait_next = r_wait_cnt;
    if (w_idle) begin
      if (!ld_req_i || w_grant_ld) begin
        w_wait_next = 4'd0;
      end else if (w_grant_cpu && (r_wait_cnt < C_MAX_WAIT)) begin
        w_wait_next = r_wait_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= 4'd0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= 32'd0;
      r_cpu_rdata <= 32'd0;
      r_ld_rdata  <= 32'd0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_wait_next;
      if (w_grant_ld) begin
        r_we    <= ld_we_i;
        r_addr  <= w_ld_addr_al;
        r_wdata <= ld_wdata_i;
      end else if (w_grant_cpu) begin
        r_we    <= cpu_we_i;
        r_addr  <= w_cpu_addr_al;
        r_wdata <= cpu_wdata_i;
      end
      if (w_cpu_load_resp) r_cpu_rdata <= mem_rdata_i;
      if (w_ld_load_resp)  r_ld_rdata  <= mem_rdata_i;
    end
  end

  // Read data is forwarded straight from memory during the response cycle, then held.
  assign w_cpu_load_resp = (r_state == S_RESP_CPU) & ~r_we;
  assign w_ld_load_resp  = (r_state == S_RESP_LD) & ~r_we;

  assign cpu_rdata_o = w_cpu_load_resp ? mem_rdata_i : r_cpu_rdata;
  assign ld_rdata_o  = w_ld_load_resp ? mem_rdata_i : r_ld_rdata;
  assign ld_ack_o    = (r_state == S_RESP_LD);

  assign mem_en_o    = (r_state == S_ISSUE_CPU) | (r_state == S_ISSUE_LD);
  assign mem_we_o    = mem_en_o & r_we;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;

  assign cpu_stall_o = w_cpu_req & (r_state != S_RESP_CPU);
  assign busy_o      = ~w_idle;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small synchronous memory model attached.
module tb_dmem_arbiter;

  localparam int ADDR_W = 5;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              start_i;
  logic              cpu_req_i;
  logic              cpu_we_i;
  logic [31:0]       cpu_addr_i;
  logic [31:0]       cpu_wdata_i;
  logic [31:0]       cpu_rdata_o;
  logic              cpu_stall_o;
  logic              ld_req_i;
  logic              ld_we_i;
  logic [ADDR_W-1:0] ld_addr_i;
  logic [31:0]       ld_wdata_i;
  logic              ld_ack_o;
  logic [31:0]       ld_rdata_o;
  logic              mem_en_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic [31:0]       mem_rdata_i;
  logic              busy_o;

  logic [31:0] mem [0:7];
  int n_cmp  = 0;
  int n_fail = 0;

  dmem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o), .cpu_stall_o(cpu_stall_o),
    .ld_req_i(ld_req_i), .ld_we_i(ld_we_i), .ld_addr_i(ld_addr_i),
    .ld_wdata_i(ld_wdata_i), .ld_ack_o(ld_ack_o), .ld_rdata_o(ld_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Single-port synchronous memory: write commits at the edge, read data valid next cycle.
  always @(posedge clk_i) begin
    if (mem_en_o) begin
      if (mem_we_o) mem[mem_addr_o[4:2]] <= mem_wdata_o;
      mem_rdata_i <= mem[mem_addr_o[4:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 32'd0;
    mem_rdata_i = 32'd0;

    // Reset with arbitrary active inputs.
    rst_i = 1'b0; start_i = 1'b1;
    cpu_req_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = $urandom; cpu_wdata_i = $urandom;
    ld_req_i = 1'b1; ld_we_i = 1'b1; ld_addr_i = 5'($urandom); ld_wdata_i = $urandom;
    #1;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_mem_en", 32'(mem_en_o), 32'd0);
    chk("rst_stall", 32'(cpu_stall_o), 32'd1);
    tick(); tick();
    chk("rst_busy_held", 32'(busy_o), 32'd0);
    chk("rst_ack", 32'(ld_ack_o), 32'd0);
    chk("rst_cpu_rdata", cpu_rdata_o, 32'd0);
    chk("rst_ld_rdata", ld_rdata_o, 32'd0);
    chk("rst_mem_we", 32'(mem_we_o), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr_o), 32'd0);
    chk("rst_mem_wdata", mem_wdata_o, 32'd0);
    cpu_req_i = 1'b0; ld_req_i = 1'b0; cpu_we_i = 1'b0; ld_we_i = 1'b0;
    rst_i = 1'b1;
    tick();

    // CPU store 5 to 0x04.
    cpu_req_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h0000_0004; cpu_wdata_i = 32'h5;
    #1 chk("st_stall_n", 32'(cpu_stall_o), 32'd1);
    tick();
    chk("st_stall_n1", 32'(cpu_stall_o), 32'd1);
    chk("st_mem_en", 32'(mem_en_o), 32'd1);
    chk("st_mem_we", 32'(mem_we_o), 32'd1);
    chk("st_mem_addr", 32'(mem_addr_o), 32'h4);
    chk("st_mem_wdata", mem_wdata_o, 32'h5);
    tick();
    chk("st_stall_n2", 32'(cpu_stall_o), 32'd0);
    chk("st_resp_en", 32'(mem_en_o), 32'd0);
    cpu_req_i = 1'b0;
    tick();
    chk("st_mem_word", mem[1], 32'h5);

    // CPU load from misaligned 0x27, which rounds down to 0x04.
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0027;
    #1 chk("ld_stall_n", 32'(cpu_stall_o), 32'd1);
    tick();
    chk("ld_stall_n1", 32'(cpu_stall_o), 32'd1);
    chk("ld_mem_we", 32'(mem_we_o), 32'd0);
    chk("ld_mem_addr_align", 32'(mem_addr_o), 32'h4);
    tick();
    chk("ld_stall_n2", 32'(cpu_stall_o), 32'd0);
    chk("ld_cpu_rdata", cpu_rdata_o, 32'h5);
    cpu_req_i = 1'b0;
    tick();
    chk("ld_cpu_rdata_held", cpu_rdata_o, 32'h5);

    // Loader preload with CPU stopped; CPU request must be ignored.
    start_i = 1'b0; cpu_req_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h0;
    ld_req_i = 1'b1; ld_we_i = 1'b1; ld_addr_i = 5'h10; ld_wdata_i = 32'hDEAD_BEEF;
    #1 chk("pl_stall_off", 32'(cpu_stall_o), 32'd0);
    tick();
    chk("pl_mem_addr", 32'(mem_addr_o), 32'h10);
    chk("pl_ack_early", 32'(ld_ack_o), 32'd0);
    tick();
    chk("pl_ack_wr", 32'(ld_ack_o), 32'd1);
    ld_req_i = 1'b0;
    tick();
    chk("pl_ack_drop", 32'(ld_ack_o), 32'd0);
    chk("pl_mem_word", mem[4], 32'hDEAD_BEEF);
    ld_req_i = 1'b1; ld_we_i = 1'b0;
    tick(); tick();
    chk("pl_ack_rd", 32'(ld_ack_o), 32'd1);
    chk("pl_ld_rdata", ld_rdata_o, 32'hDEAD_BEEF);
    ld_req_i = 1'b0;
    tick();
    chk("pl_ld_rdata_held", ld_rdata_o, 32'hDEAD_BEEF);
    chk("pl_stall_still_off", 32'(cpu_stall_o), 32'd0);
    chk("pl_cpu_ignored", 32'(busy_o), 32'd0);
    cpu_req_i = 1'b0; cpu_we_i = 1'b0;

    // Fairness: continuous requests from both sides give CCCCL CCCCL.
    start_i = 1'b1;
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0008;
    ld_req_i = 1'b1; ld_we_i = 1'b0; ld_addr_i = 5'h10;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("fair_grant_%0d", k), 32'(mem_addr_o), (k % 5 == 4) ? 32'h10 : 32'h8);
      tick(); tick();
    end
    cpu_req_i = 1'b0; ld_req_i = 1'b0;
    tick();

    // Collision: CPU request rises while the loader is in ISSUE_LD.
    ld_req_i = 1'b1; ld_we_i = 1'b1; ld_addr_i = 5'h14; ld_wdata_i = 32'h1234_5678;
    tick();
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0004;
    #1 chk("col_stall_1", 32'(cpu_stall_o), 32'd1);
    tick();
    chk("col_stall_2", 32'(cpu_stall_o), 32'd1);
    chk("col_ack", 32'(ld_ack_o), 32'd1);
    ld_req_i = 1'b0;
    tick();
    chk("col_stall_3", 32'(cpu_stall_o), 32'd1);
    tick();
    chk("col_stall_4", 32'(cpu_stall_o), 32'd1);
    chk("col_cpu_addr", 32'(mem_addr_o), 32'h4);
    tick();
    chk("col_stall_end", 32'(cpu_stall_o), 32'd0);
    chk("col_cpu_rdata", cpu_rdata_o, 32'h5);
    cpu_req_i = 1'b0;
    tick();
    chk("col_ld_word", mem[5], 32'h1234_5678);

    // start_i falls mid CPU load; the access still completes and updates read data.
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0010;
    tick();
    start_i = 1'b0;
    #1 chk("sf_stall_off", 32'(cpu_stall_o), 32'd0);
    tick();
    chk("sf_cpu_rdata", cpu_rdata_o, 32'hDEAD_BEEF);
    cpu_req_i = 1'b0; start_i = 1'b1;
    tick();

    // Reset asserted during ISSUE_CPU of a store aborts the write.
    cpu_req_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h0000_0004; cpu_wdata_i = 32'hAAAA_5555;
    tick();
    chk("rw_issue_en", 32'(mem_en_o), 32'd1);
    rst_i = 1'b0;
    #1;
    chk("rw_en_drop", 32'(mem_en_o), 32'd0);
    chk("rw_we_drop", 32'(mem_we_o), 32'd0);
    chk("rw_busy_drop", 32'(busy_o), 32'd0);
    tick();
    chk("rw_mem_unchanged", mem[1], 32'h5);
    chk("rw_cpu_rdata_rst", cpu_rdata_o, 32'd0);
    cpu_req_i = 1'b0;
    rst_i = 1'b1;
    tick();
    chk("rw_idle_after", 32'(busy_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and access sequencer for the single-port synchronous data memory. It shares the memory between the pipeline MEM stage and an external loader/dump port, and stalls the pipeline while a CPU access is in flight. CPU requests have priority; a bounded-wait counter guarantees loader progress. It sits between the EX_MEM/MEM_WB boundary, the loader port and the data memory.

## Interface
Parameters:
- ADDR_W, 5: byte-address width of data memory (32 bytes).
- MAX_WAIT, 4: number of consecutive arbitration losses after which the loader wins. Range 1..15.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  CPU running; while 0, CPU requests are ignored.
- cpu_req_i  in  1  MEM-stage access request (MemRead|MemWrite).
- cpu_we_i  in  1  1 = store, 0 = load.
- cpu_addr_i  in  32  byte address.
- cpu_wdata_i  in  32  store data.
- cpu_rdata_o  out  32  load data.
- cpu_stall_o  out  1  freeze PC/IF_ID/ID_EX/EX_MEM.
- ld_req_i  in  1  loader request, held until ld_ack_o.
- ld_we_i  in  1  loader write enable.
- ld_addr_i  in  ADDR_W  loader byte address.
- ld_wdata_i  in  32  loader write data.
- ld_ack_o  out  1  one-cycle completion pulse.
- ld_rdata_o  out  32  loader read data.
- mem_en_o, mem_we_o  out  1 each  memory strobe / write enable.
- mem_addr_o  out  ADDR_W  memory byte address, bits [1:0] forced 0.
- mem_wdata_o  out  32  memory write data.
- mem_rdata_i  in  32  memory read data, valid the cycle after mem_en_o.
- busy_o  out  1  state != IDLE.

## Operation
- States: IDLE, ISSUE_CPU, RESP_CPU, ISSUE_LD, RESP_LD.
- Effective CPU request: cpu_req_i & start_i.
- IDLE: at clock edge, if loader request and wait_cnt == MAX_WAIT -> ISSUE_LD; else if CPU request -> ISSUE_CPU; else if ld_req_i -> ISSUE_LD; else stay.
- ISSUE_x: mem_en_o=1, mem_we_o/addr/wdata from registered copy of winner's request (captured at IDLE->ISSUE edge). Always -> RESP_x.
- RESP_x: mem_en_o=0; read data = mem_rdata_i. Always -> IDLE (no back-to-back; requester updates after completion).
- RESP_CPU: cpu_rdata_o = mem_rdata_i (combinational), register updated at end of cycle; elsewhere cpu_rdata_o holds last load value. Stores do not update it.
- RESP_LD: ld_ack_o=1, ld_rdata_o = mem_rdata_i; held afterwards likewise.
- cpu_stall_o = effective CPU request & (state != RESP_CPU). Combinational; 0 when start_i=0.
- wait_cnt (4 bit): +1 at each IDLE edge where ld_req_i=1 and CPU wins; cleared on loader grant or when ld_req_i=0 in IDLE; saturates at MAX_WAIT.
- Address: low ADDR_W bits of requester address, bits [1:0] cleared (misaligned accesses round down; no error).
- Writes commit in memory at end of ISSUE cycle.

## Timing
- Reset (async, rst_i=0): state IDLE, wait_cnt 0, all registered outputs 0 (cpu_rdata_o, ld_rdata_o, ld_ack_o, mem_* and busy_o). cpu_stall_o follows its equation (stalls if CPU requests while in reset IDLE). mem_en_o drops immediately: an in-flight write is aborted; in-flight requester must reissue.
- CPU access, memory idle: req seen cycle N -> ISSUE N+1 -> RESP N+2; stall high N, N+1, low N+2; pipeline advances at end of N+2. Cost: 2 stall cycles.
- Loader access: ld_req_i at N -> ld_ack_o in N+2; loader may drive new request in N+3, earliest ISSUE N+4.
- CPU request arriving during loader access: stalls until the loader completes; worst case 2 + 3 = 5 stall cycles.
- Simultaneous requests in IDLE: CPU wins unless wait_cnt == MAX_WAIT.
- start_i falling mid CPU access: access completes; RESP still updates cpu_rdata_o.

## Test plan
- Reset values: rst_i=0 with random inputs -> all registered outputs 0, busy_o=0, mem_en_o=0 asynchronously.
- CPU store then load: store 0x0000_0005 at 0x04, load 0x04 -> mem_we_o pulse in ISSUE, cpu_stall_o high exactly 2 cycles each, cpu_rdata_o=5 in RESP.
- Loader preload with start_i=0: write 0x10=0xDEADBEEF, read back -> ld_ack_o 2 cycles after each request, ld_rdata_o=0xDEADBEEF; cpu_req_i=1 ignored, cpu_stall_o=0.
- Fairness, MAX_WAIT=4: CPU and loader request continuously -> loader granted after exactly 4 CPU grants, pattern CCCCL repeating.
- Collision: loader in ISSUE_LD when cpu_req_i rises -> CPU granted immediately after RESP_LD, stall 4 cycles from this point; loader data unaffected.
- Reset mid-write: rst_i low during ISSUE_CPU with cpu_we_i=1 -> mem_en_o falls before the edge, memory word unchanged, FSM in IDLE.
